// File: rtl/arthas_buf_pkg.sv
// Shared types and config-field layout for the single-replay buffer and its
// consumers.
package arthas_buf_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CAPT  = 3'd2,
    WGT   = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam int MAX_NDATA   = 1024;
  localparam int MAX_NPERIOD = 524288;

  // config_bits = {nPeriod, nData}; nData occupies the LSBs
  localparam int NDATA_W     = $clog2(MAX_NDATA);
  localparam int NPERIOD_W   = $clog2(MAX_NPERIOD);
  localparam int NDATA_LSB   = 0;
  localparam int NPERIOD_LSB = NDATA_W;
  localparam int CFG_W       = NDATA_W + NPERIOD_W;

endpackage

// File: rtl/singbuf_dot_consumer_if.sv
// Buffer read, weight stream and result ports of the dot-product consumer.
interface singbuf_dot_consumer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 74
);
  logic                  buf_rrdy;
  logic                  buf_re;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_valid;
  logic                  w_ready;
  logic [ACC_WIDTH-1:0]  res_data;
  logic                  res_valid;
  logic                  res_ready;

  modport master (
    input  buf_rrdy, buf_data, w_data, w_valid, res_ready,
    output buf_re, w_ready, res_data, res_valid
  );

  modport slave (
    output buf_rrdy, buf_data, w_data, w_valid, res_ready,
    input  buf_re, w_ready, res_data, res_valid
  );
endinterface

// File: rtl/singbuf_dot_consumer_mac.sv
// Signed multiply-accumulate; the product is sign-extended (or truncated) to
// the accumulator width and the sum wraps.
module dot_mac_acc #(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 74
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic        [ACC_WIDTH-1:0]  acc
);

  localparam int PROD_W = 2 * DATA_WIDTH;

  logic signed [PROD_W-1:0] prod_s;
  logic [ACC_WIDTH-1:0]     prod_ext_s;

  assign prod_s = a * b;

  if (ACC_WIDTH > PROD_W) begin : g_sext
    assign prod_ext_s = {{(ACC_WIDTH - PROD_W){prod_s[PROD_W-1]}}, prod_s};
  end else begin : g_trunc
    assign prod_ext_s = prod_s[ACC_WIDTH-1:0];
  end

  // accumulator register: clear beats enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc <= {ACC_WIDTH{1'b0}};
    end else if (clr) begin
      acc <= {ACC_WIDTH{1'b0}};
    end else if (en) begin
      acc <= acc + prod_ext_s;
    end else begin
      acc <= acc;
    end
  end

endmodule

// File: rtl/singbuf_dot_consumer.sv
// Replays a buffered vector nPeriod times, dotting it against a weight stream
// and emitting one result per period.
module singbuf_dot_consumer
  import arthas_buf_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int MAX_nDATA   = MAX_NDATA,
  parameter int MAX_nPERIOD = MAX_NPERIOD,
  parameter int ACC_WIDTH   = 2 * DATA_WIDTH + $clog2(MAX_nDATA)
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [$clog2(MAX_nDATA)+$clog2(MAX_nPERIOD)-1:0] config_bits,
  input  logic                                           start,
  singbuf_dot_consumer_if.master                         bus,
  output logic                                           busy,
  output logic                                           done
);

  localparam int ND_W = $clog2(MAX_nDATA);
  localparam int NP_W = $clog2(MAX_nPERIOD);

  state_t                  state_r;
  logic [ND_W-1:0]         nd_r;
  logic [NP_W-1:0]         np_r;
  logic [ND_W-1:0]         data_count_r;
  logic [NP_W-1:0]         period_count_r;
  logic [DATA_WIDTH-1:0]   a_r;
  logic                    w_ready_r;
  logic                    res_valid_r;
  logic [ACC_WIDTH-1:0]    acc_s;

  logic [ND_W-1:0]         nd_cand_s;
  logic [NP_W-1:0]         np_cand_s;
  logic                    start_ok_s;
  logic                    mac_clr_s;
  logic                    mac_en_s;

  assign nd_cand_s = config_bits[ND_W-1:0];
  assign np_cand_s = config_bits[ND_W +: NP_W];

  // start qualification and accumulator control
  always_comb begin
    start_ok_s = 1'b0;
    mac_clr_s  = 1'b0;
    mac_en_s   = 1'b0;
    if (state_r == IDLE) begin
      start_ok_s = start && (nd_cand_s != {ND_W{1'b0}}) && (np_cand_s != {NP_W{1'b0}});
      mac_clr_s  = start_ok_s;
    end else if (state_r == WGT) begin
      mac_en_s   = bus.w_valid;
    end else if (state_r == OUT) begin
      mac_clr_s  = bus.res_ready;
    end else begin
      mac_en_s   = 1'b0;
    end
  end

  // the read strobe follows rrdy so a stalled buffer never sees a spurious re
  assign bus.buf_re    = (state_r == FETCH) && bus.buf_rrdy;
  assign bus.w_ready   = w_ready_r;
  assign bus.res_valid = res_valid_r;
  // acc only moves in WGT or on acceptance, so it is stable throughout OUT
  assign bus.res_data  = acc_s;

  // sequencing FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= IDLE;
      nd_r           <= {ND_W{1'b0}};
      np_r           <= {NP_W{1'b0}};
      data_count_r   <= {ND_W{1'b0}};
      period_count_r <= {NP_W{1'b0}};
      a_r            <= {DATA_WIDTH{1'b0}};
      w_ready_r      <= 1'b0;
      res_valid_r    <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start_ok_s) begin
            nd_r           <= nd_cand_s;
            np_r           <= np_cand_s;
            data_count_r   <= {ND_W{1'b0}};
            period_count_r <= {NP_W{1'b0}};
            busy           <= 1'b1;
            state_r        <= FETCH;
          end
        end
        FETCH: begin
          if (bus.buf_rrdy) begin
            state_r <= CAPT;
          end
        end
        CAPT: begin
          a_r       <= bus.buf_data;
          w_ready_r <= 1'b1;
          state_r   <= WGT;
        end
        WGT: begin
          if (bus.w_valid) begin
            w_ready_r <= 1'b0;
            if (data_count_r == nd_r - {{(ND_W-1){1'b0}}, 1'b1}) begin
              data_count_r <= {ND_W{1'b0}};
              res_valid_r  <= 1'b1;
              state_r      <= OUT;
            end else begin
              data_count_r <= data_count_r + {{(ND_W-1){1'b0}}, 1'b1};
              state_r      <= FETCH;
            end
          end
        end
        OUT: begin
          if (bus.res_ready) begin
            res_valid_r <= 1'b0;
            if (period_count_r == np_r - {{(NP_W-1){1'b0}}, 1'b1}) begin
              period_count_r <= {NP_W{1'b0}};
              busy           <= 1'b0;
              done           <= 1'b1;
              state_r        <= IDLE;
            end else begin
              period_count_r <= period_count_r + {{(NP_W-1){1'b0}}, 1'b1};
              state_r        <= FETCH;
            end
          end
        end
        default: begin
          w_ready_r   <= 1'b0;
          res_valid_r <= 1'b0;
          busy        <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  dot_mac_acc #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(mac_clr_s),
    .en (mac_en_s),
    .a  ($signed(a_r)),
    .b  ($signed(bus.w_data)),
    .acc(acc_s)
  );

endmodule
